alu_serial: RTL and testbench

//  Multi-cycle, slice-serial successor to the combinational 8-bit ALU. Operates on DATA_W-bit

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_slice.sv | 37 +++
 rtl/alu_serial.sv | 170 +++++++++++++++++
 tb/tb_alu_serial.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the slice-serial ALU: flags, op codes, FSM states
package alu_pkg;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_ADC     = 4'd1,
        OP_SUB     = 4'd2,
        OP_SBC     = 4'd3,
        OP_CP      = 4'd4,
        OP_AND     = 4'd5,
        OP_XOR     = 4'd6,
        OP_OR      = 4'd7,
        OP_ADD_W   = 4'd8,
        OP_ADD_SPE = 4'd9
    } ser_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ser_state_t;

    function automatic logic is_sub(ser_op_t op);
        return op inside {OP_SUB, OP_SBC, OP_CP};
    endfunction

    function automatic logic is_byte_op(ser_op_t op);
        return op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP, OP_AND, OP_XOR, OP_OR};
    endfunction

endpackage

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - combinational SLICE_W-bit add/logic slice with per-bit carry outputs
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  ser_op_t            op,
    output logic [SLICE_W-1:0] r,
    output logic [SLICE_W-1:0] carry
);

    logic [SLICE_W-1:0] bx;
    logic               cy;

    // Every bit's carry is exported so H/C can be taken from mid-slice bits when SLICE_W=8.
    always_comb begin
        bx    = is_sub(op) ? ~b : b;
        cy    = cin;
        r     = '0;
        carry = '0;
        for (int j = 0; j < SLICE_W; j++) begin
            r[j]     = a[j] ^ bx[j] ^ cy;
            cy       = (a[j] & bx[j]) | (cy & (a[j] ^ bx[j]));
            carry[j] = cy;
        end
        case (op)
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - multi-cycle ALU running one SLICE_W-bit slice per clock
module alu_serial
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              flush_i,
    input  ser_op_t           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  flags_t            flags_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] res_o,
    output flags_t            flags_o
);

    localparam int NSL   = DATA_W / SLICE_W;
    localparam int CNT_W = $clog2(NSL + 1);

    if (!(SLICE_W inside {1, 2, 4, 8}) || (DATA_W % SLICE_W) != 0 || DATA_W < 8) begin : g_param_check
        $error("alu_serial: illegal DATA_W/SLICE_W combination");
    end

    ser_state_t        state, state_nxt;
    logic              accept, last, run_step;
    logic [DATA_W-1:0] a_sh, b_sh, r_sh, r_nxt, res_fin;
    ser_op_t           op_q;
    flags_t            flags_q, flags_fin;
    logic              carry_q, h_q, c_q, h_cap, c_cap, sub;
    logic [CNT_W-1:0]  cnt, n_q, n_sel;
    logic [SLICE_W-1:0] sl_r, sl_carry;
    logic [7:0]        r8;
    int                base, hb, cb;

    assign accept   = start_i && ready_o;
    assign last     = (cnt == n_q - 1'b1);
    assign run_step = (state == ST_RUN) && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush_i)   state_nxt = ST_IDLE;
                else if (last) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = start_i ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == ST_IDLE) || (state == ST_DONE);
        busy_o  = (state == ST_RUN);
        done_o  = (state == ST_DONE);
    end

    alu_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a     (a_sh[SLICE_W-1:0]),
        .b     (b_sh[SLICE_W-1:0]),
        .cin   (carry_q),
        .op    (op_q),
        .r     (sl_r),
        .carry (sl_carry)
    );

    // Results enter at the top, so after a byte op's slices the byte sits in the upper 8 bits.
    assign r_nxt = (r_sh >> SLICE_W) | (DATA_W'(sl_r) << (DATA_W - SLICE_W));
    assign r8    = r_nxt[DATA_W-1 -: 8];
    assign sub   = is_sub(op_q);

    always_comb begin
        if (is_byte_op(op_i))                         n_sel = CNT_W'(8 / SLICE_W);
        else if (op_i inside {OP_ADD_W, OP_ADD_SPE})  n_sel = CNT_W'(NSL);
        else                                          n_sel = CNT_W'(1);
    end

    // H/C are the carries out of fixed bit positions; pick them off whichever slice holds them.
    always_comb begin
        base  = int'(cnt) * SLICE_W;
        hb    = (op_q == OP_ADD_W) ? DATA_W - 5 : 3;
        cb    = (op_q == OP_ADD_W) ? DATA_W - 1 : 7;
        h_cap = h_q;
        c_cap = c_q;
        for (int j = 0; j < SLICE_W; j++) begin
            if (base + j == hb) h_cap = sl_carry[j];
            if (base + j == cb) c_cap = sl_carry[j];
        end
    end

    always_comb begin
        res_fin   = '0;
        flags_fin = flags_q;
        case (op_q)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
                res_fin   = (op_q == OP_CP) ? '0 : DATA_W'(r8);
                flags_fin = '{z: (r8 == 8'h00), n: sub, h: h_cap ^ sub, c: c_cap ^ sub};
            end
            OP_AND: begin
                res_fin   = DATA_W'(r8);
                flags_fin = '{z: (r8 == 8'h00), n: 1'b0, h: 1'b1, c: 1'b0};
            end
            OP_XOR, OP_OR: begin
                res_fin   = DATA_W'(r8);
                flags_fin = '{z: (r8 == 8'h00), n: 1'b0, h: 1'b0, c: 1'b0};
            end
            OP_ADD_W: begin
                res_fin   = r_nxt;
                flags_fin = '{z: flags_q.z, n: 1'b0, h: h_cap, c: c_cap};
            end
            OP_ADD_SPE: begin
                res_fin   = r_nxt;
                flags_fin = '{z: 1'b0, n: 1'b0, h: h_cap, c: c_cap};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            op_q    <= OP_ADD;
            flags_q <= '0;
            n_q     <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            h_q     <= 1'b0;
            c_q     <= 1'b0;
            res_o   <= '0;
            flags_o <= '0;
        end else if (accept) begin
            a_sh    <= a_i;
            b_sh    <= (op_i == OP_ADD_SPE) ? {{(DATA_W-8){b_i[7]}}, b_i[7:0]} : b_i;
            r_sh    <= '0;
            op_q    <= op_i;
            flags_q <= flags_i;
            n_q     <= n_sel;
            cnt     <= '0;
            carry_q <= (((op_i == OP_ADC) || (op_i == OP_SBC)) ? flags_i.c : 1'b0) ^ is_sub(op_i);
            h_q     <= 1'b0;
            c_q     <= 1'b0;
        end else if (run_step) begin
            a_sh    <= a_sh >> SLICE_W;
            b_sh    <= b_sh >> SLICE_W;
            r_sh    <= r_nxt;
            carry_q <= sl_carry[SLICE_W-1];
            h_q     <= h_cap;
            c_q     <= c_cap;
            cnt     <= cnt + 1'b1;
            if (last) begin
                res_o   <= res_fin;
                flags_o <= flags_fin;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// tb/tb_alu_serial.sv - scoreboard bench for alu_serial (DATA_W=16, SLICE_W=4)
module tb_alu_serial;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    ser_op_t     op_i = OP_ADD;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    flags_t      flags_i = '0;
    logic        ready_o, busy_o, done_o;
    logic [15:0] res_o;
    flags_t      flags_o;

    alu_serial #(.DATA_W(16), .SLICE_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .flush_i (flush_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flags_i (flags_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .res_o   (res_o),
        .flags_o (flags_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [15:0] last_res = '0;
    logic [3:0]  last_fl = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: whole-byte / whole-word arithmetic, returns {res, z, n, h, c}.
    function automatic logic [19:0] model(ser_op_t op, logic [15:0] a, logic [15:0] b, logic [3:0] f);
        logic        cin, h, c;
        logic [8:0]  s9;
        logic [16:0] s17;
        logic [15:0] e;
        logic [7:0]  r8;
        model = {16'h0000, f};
        case (op)
            OP_ADD, OP_ADC: begin
                cin = (op == OP_ADC) ? f[0] : 1'b0;
                s9  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(cin);
                h   = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(cin)) > 5'd15;
                model = {8'h00, s9[7:0], (s9[7:0] == 8'h00), 1'b0, h, s9[8]};
            end
            OP_SUB, OP_SBC, OP_CP: begin
                cin = (op == OP_SBC) ? f[0] : 1'b0;
                r8  = a[7:0] - b[7:0] - 8'(cin);
                h   = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + 5'(cin));
                c   = {1'b0, a[7:0]} < ({1'b0, b[7:0]} + 9'(cin));
                model = {((op == OP_CP) ? 16'h0000 : {8'h00, r8}), (r8 == 8'h00), 1'b1, h, c};
            end
            OP_AND: begin r8 = a[7:0] & b[7:0]; model = {8'h00, r8, (r8 == 8'h00), 3'b010}; end
            OP_XOR: begin r8 = a[7:0] ^ b[7:0]; model = {8'h00, r8, (r8 == 8'h00), 3'b000}; end
            OP_OR:  begin r8 = a[7:0] | b[7:0]; model = {8'h00, r8, (r8 == 8'h00), 3'b000}; end
            OP_ADD_W: begin
                s17 = {1'b0, a} + {1'b0, b};
                h   = ({1'b0, a[11:0]} + {1'b0, b[11:0]}) > 13'h0FFF;
                model = {s17[15:0], f[3], 1'b0, h, s17[16]};
            end
            OP_ADD_SPE: begin
                e   = {{8{b[7]}}, b[7:0]};
                s17 = {1'b0, a} + {1'b0, e};
                h   = ({1'b0, a[3:0]} + {1'b0, e[3:0]}) > 5'd15;
                c   = ({1'b0, a[7:0]} + {1'b0, e[7:0]}) > 9'd255;
                model = {s17[15:0], 2'b00, h, c};
            end
            default: ;
        endcase
    endfunction

    function automatic int slices(ser_op_t op);
        if (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP, OP_AND, OP_XOR, OP_OR}) return 2;
        if (op inside {OP_ADD_W, OP_ADD_SPE}) return 4;
        return 1;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic issue(ser_op_t op, logic [15:0] a, logic [15:0] b, logic [3:0] f,
                         bit expect_done, bit fl);
        logic [19:0] m;
        exp_t        e;
        int          n;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        flags_i = flags_t'(f);
        start_i = 1'b1;
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            check("accept_timeout", 32'd0, 32'd1);
            start_i = 1'b0;
            return;
        end
        flush_i = fl;
        if (expect_done) begin
            m     = model(op, a, b, f);
            e.res = m[19:4];
            e.fl  = m[3:0];
            e.cyc = cyc + 1 + slices(op);
            sb.push_back(e);
        end
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        start_i = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("res", 32'(res_o), 32'(mon_e.res));
                check("flags", 32'(flags_o), 32'(mon_e.fl));
                check("latency", 32'(cyc), 32'(mon_e.cyc));
                last_res = mon_e.res;
                last_fl  = mon_e.fl;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_res", 32'(res_o), 32'd0);
        check("rst_flags", 32'(flags_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OP_ADD, 16'h003A, 16'h00C6, 4'b0000, 1, 0); drain();
        issue(OP_SBC, 16'h0000, 16'h0000, 4'b0001, 1, 0); drain();
        issue(OP_SUB, 16'h0010, 16'h0001, 4'b0000, 1, 0); drain();
        issue(OP_ADD_W, 16'h0FFF, 16'h0001, 4'b1000, 1, 0); drain();
        issue(OP_ADD_SPE, 16'hFFF8, 16'h0008, 4'b1111, 1, 0); drain();
        issue(OP_ADD_SPE, 16'h0000, 16'h00FF, 4'b0000, 1, 0); drain();
        issue(OP_CP, 16'hAB42, 16'hCD42, 4'b0000, 1, 0); drain();
        issue(OP_ADC, 16'h120F, 16'h3400, 4'b0001, 1, 0); drain();
        issue(OP_AND, 16'hFFF0, 16'hFF0F, 4'b0000, 1, 0); drain();
        issue(OP_XOR, 16'h5A5A, 16'h33C3, 4'b0000, 1, 0); drain();
        issue(OP_OR, 16'h9900, 16'h7700, 4'b0000, 1, 0); drain();
        issue(ser_op_t'(4'd13), 16'h1234, 16'h5678, 4'b1010, 1, 0); drain();

        // Back-to-back with start held; later operands change while the earlier op runs.
        issue(OP_ADD, 16'h0081, 16'h0081, 4'b0000, 1, 0);
        issue(OP_SUB, 16'h0003, 16'h0005, 4'b0000, 1, 0);
        issue(OP_XOR, 16'h00FF, 16'h00FF, 4'b0000, 1, 0);
        drain();

        // flush_i is ignored in IDLE and loses to start_i in DONE.
        issue(OP_ADC, 16'h00FF, 16'h0000, 4'b0001, 1, 1);
        issue(OP_SBC, 16'h0020, 16'h0010, 4'b0001, 1, 1);
        drain();

        issue(OP_ADD, 16'h0011, 16'h0022, 4'b0000, 0, 0);
        start_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_ready", 32'(ready_o), 32'd1);
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_res", 32'(res_o), 32'(last_res));
        check("flush_flags", 32'(flags_o), 32'(last_fl));
        repeat (6) @(negedge clk);

        issue(OP_ADD_W, 16'h7777, 16'h1111, 4'b0000, 0, 0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready_o), 32'd1);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check("mid_rst_res", 32'(res_o), 32'd0);
        check("mid_rst_flags", 32'(flags_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        last_fl  = '0;
        repeat (6) @(negedge clk);

        issue(OP_ADD, 16'h0040, 16'h0041, 4'b0000, 1, 0); drain();

        for (int i = 0; i < 40; i++) begin
            issue(ser_op_t'($urandom_range(0, 11)), 16'($urandom), 16'($urandom),
                  4'($urandom), 1, 0);
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
